// File: rtl/gate_pkg.sv
// Shared types and constants for the NAND-derived gate self-test sequencer.
// Gate output bit order: {nor, nand, and, or, b_not, a_not}, with a_not at bit 0.
package gate_pkg;

  localparam int GATE_W = 6;

  localparam int A_NOT = 0;
  localparam int B_NOT = 1;
  localparam int OR    = 2;
  localparam int AND   = 3;
  localparam int NAND  = 4;
  localparam int NOR   = 5;

  // Golden outputs, indexed by the vector {a, b}.
  localparam logic [GATE_W-1:0] EXP [4] = '{6'h33, 6'h15, 6'h16, 6'h0C};

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

endpackage

// File: rtl/gate_expect_rom.sv
// Combinational golden truth table.
// Maps the 2-bit input vector {a, b} to the six expected gate outputs.
module gate_expect_rom
  import gate_pkg::*;
(
  input  logic [1:0]        vec_i,
  output logic [GATE_W-1:0] exp_o
);

  assign exp_o = EXP[vec_i];

endmodule

// File: rtl/nand_gate_sweep_ctrl.sv
// Self-test sequencer: sweeps a/b over all four vectors, waits a settle interval,
// then checks the gate block's outputs against the golden table.
module nand_gate_sweep_ctrl
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_in,
  output logic              a_out,
  output logic              b_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        err_count,
  output logic [GATE_W-1:0] fail_mask
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_e            state_q;
  logic [1:0]        vec_q;
  logic [3:0]        cnt_q;
  logic              a_q, b_q, busy_q, done_q, pass_q;
  logic [2:0]        err_q;
  logic [GATE_W-1:0] mask_q;

  logic [GATE_W-1:0] exp_d;
  logic [GATE_W-1:0] mism_d;

  gate_expect_rom u_rom (
    .vec_i (vec_q),
    .exp_o (exp_d)
  );

  assign mism_d = gate_in ^ exp_d;

  // Abort wins over normal progress everywhere except DONE, which always completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      mask_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q == S_APPLY || state_q == S_SETTLE || state_q == S_CHECK)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        a_q     <= 1'b0;
        b_q     <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            a_q <= 1'b0;
            b_q <= 1'b0;
            if (start && !abort) begin
              state_q <= S_APPLY;
              err_q   <= 3'd0;
              mask_q  <= '0;
              pass_q  <= 1'b0;
              vec_q   <= 2'd0;
            end
          end
          S_APPLY: begin
            a_q     <= vec_q[1];
            b_q     <= vec_q[0];
            busy_q  <= 1'b1;
            cnt_q   <= SETTLE_LD;
            state_q <= (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
          end
          S_SETTLE: begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
              state_q <= S_CHECK;
            end
          end
          S_CHECK: begin
            mask_q <= mask_q | mism_d;
            if ((|mism_d) && (err_q < 3'd4)) begin
              err_q <= err_q + 3'd1;
            end
            if (vec_q == 2'd3) begin
              state_q <= S_DONE;
            end else begin
              vec_q   <= vec_q + 2'd1;
              state_q <= S_APPLY;
            end
          end
          S_DONE: begin
            done_q  <= 1'b1;
            pass_q  <= (mask_q == '0);
            busy_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule
